// File: rtl/put_next_line.sv
// Line-buffer writer: packs a 12-bit RGB stream into fixed-length line slots on
// BRAM port A, padding short lines, truncating long ones, and throttling when full.
module put_next_line #(
  parameter int unsigned ADDRESS_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned LINE_COUNT_POW  = 1,
  parameter int unsigned LINE_WIDTH      = 640,
  parameter int unsigned PIXEL_COUNT_POW = 10
) (
  input  logic                        clk,
  input  logic                        reset_n,
  output logic                        clka,
  output logic                        rsta,
  output logic                        ena,
  output logic [DATA_WIDTH/8-1:0]     wea,
  output logic [ADDRESS_WIDTH-1:0]    addra,
  output logic [DATA_WIDTH-1:0]       dina,
  input  logic [11:0]                 s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic                        s_last,
  input  logic                        frame_sync,
  input  logic                        line_consumed,
  output logic [LINE_COUNT_POW:0]     lines_filled,
  output logic                        err_short,
  output logic                        err_long
);

  localparam int unsigned WE_W = DATA_WIDTH / 8;
  localparam int unsigned LF_W = LINE_COUNT_POW + 1;
  localparam int unsigned SLOT_W = LINE_COUNT_POW;
  localparam int unsigned IDX_W = PIXEL_COUNT_POW;
  localparam logic [LF_W-1:0] LINES_FULL = LF_W'(2 ** LINE_COUNT_POW);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_PAD,
    ST_DISCARD,
    ST_WAIT
  } state_t;

  state_t state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [LF_W-1:0]   lf_d;
  logic              err_short_d, err_long_d, s_ready_d;
  logic              ena_d;
  logic [WE_W-1:0]   wea_d;
  logic [ADDRESS_WIDTH-1:0] addra_d;
  logic [DATA_WIDTH-1:0]    dina_d;
  logic              accept, complete, resume, consume;

  assign clka = clk;
  assign rsta = ~reset_n;
  assign accept = s_valid & s_ready;

  // Next-state, write issue and occupancy bookkeeping
  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    idx_d       = idx_q;
    err_short_d = err_short;
    err_long_d  = err_long;
    ena_d       = 1'b0;
    wea_d       = '0;
    addra_d     = addra;
    dina_d      = dina;
    complete    = 1'b0;
    resume      = 1'b0;
    consume     = 1'b0;
    lf_d        = lines_filled;
    s_ready_d   = 1'b0;

    case (state_q)
      ST_FILL: begin
        if (accept) begin
          ena_d   = 1'b1;
          wea_d   = '1;
          addra_d = ADDRESS_WIDTH'({slot_q, idx_q});
          dina_d  = DATA_WIDTH'(s_data);
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) begin
            complete = 1'b1;
            if (s_last) begin
              resume = 1'b1;
            end else begin
              err_long_d = 1'b1;
              state_d    = ST_DISCARD;
            end
          end else if (s_last) begin
            err_short_d = 1'b1;
            state_d     = ST_PAD;
          end
        end
      end
      ST_PAD: begin
        ena_d   = 1'b1;
        wea_d   = '1;
        addra_d = ADDRESS_WIDTH'({slot_q, idx_q});
        dina_d  = '0;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          complete = 1'b1;
          resume   = 1'b1;
        end
      end
      ST_DISCARD: begin
        if (accept && s_last) resume = 1'b1;
      end
      ST_WAIT: begin
        resume = 1'b1;
      end
      default: ;
    endcase

    if (complete) begin
      slot_d = slot_q + SLOT_W'(1);
      idx_d  = '0;
    end

    // A consume on an empty count is dropped so the counter cannot wrap
    consume = line_consumed && (lines_filled != '0);
    lf_d = lines_filled + LF_W'(complete) - LF_W'(consume);

    if (resume) state_d = (lf_d == LINES_FULL) ? ST_WAIT : ST_FILL;

    if (frame_sync) begin
      state_d     = ST_FILL;
      slot_d      = '0;
      idx_d       = '0;
      lf_d        = '0;
      err_short_d = 1'b0;
      err_long_d  = 1'b0;
      ena_d       = 1'b0;
      wea_d       = '0;
    end

    s_ready_d = ((state_d == ST_FILL) && (lf_d != LINES_FULL)) || (state_d == ST_DISCARD);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      slot_q       <= '0;
      idx_q        <= '0;
      lines_filled <= '0;
      err_short    <= 1'b0;
      err_long     <= 1'b0;
      s_ready      <= 1'b0;
      ena          <= 1'b0;
      wea          <= '0;
      addra        <= '0;
      dina         <= '0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      idx_q        <= idx_d;
      lines_filled <= lf_d;
      err_short    <= err_short_d;
      err_long     <= err_long_d;
      s_ready      <= s_ready_d;
      ena          <= ena_d;
      wea          <= wea_d;
      addra        <= addra_d;
      dina         <= dina_d;
    end
  end

endmodule
